// File: rtl/common_lru_pkg.sv
// -----------------------------------------------------------------------------
// common_lru_pkg
// Shared definitions for the LRU way allocator:
//   STATE_IDLE / STATE_ALLOC  allocator state encodings
//   alloc_state_t             enum built on those encodings
//   onehot_check(vec)         1 when vec has exactly one bit set (vec up to
//                             MAX_WAYS bits, zero-extended by the caller)
// -----------------------------------------------------------------------------
package common_lru_pkg;

  localparam logic STATE_IDLE  = 1'b0;
  localparam logic STATE_ALLOC = 1'b1;

  localparam int MAX_WAYS = 16;

  typedef enum logic {
    ST_IDLE  = STATE_IDLE,
    ST_ALLOC = STATE_ALLOC
  } alloc_state_t;

  function automatic bit onehot_check(input logic [MAX_WAYS-1:0] vec);
    logic [MAX_WAYS-1:0] one;
    one = {{(MAX_WAYS-1){1'b0}}, 1'b1};
    return (vec != '0) && ((vec & (vec - one)) == '0);
  endfunction

endpackage

// File: rtl/common_lru_way_prio_onehot.sv
// -----------------------------------------------------------------------------
// common_lru_way_prio_onehot
// Lowest-set-bit isolator. Output has only the lowest set bit of vec;
// an all-zero input gives an all-zero output.
// Ports:
//   vec  in   W  input vector
//   low  out  W  one-hot (or zero) lowest set bit of vec
// -----------------------------------------------------------------------------
module common_lru_way_prio_onehot #(
  parameter int W = 4
) (
  input  logic [W-1:0] vec,
  output logic [W-1:0] low
);

  // seen[i] = some bit below i is set
  logic [W-1:0] seen;

  assign seen[0] = 1'b0;

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    assign low[gi] = vec[gi] & ~seen[gi];
    if (gi < W - 1) begin : g_chain
      assign seen[gi+1] = seen[gi] | vec[gi];
    end
  end

endmodule

// File: rtl/common_lru_way_allocator.sv
// -----------------------------------------------------------------------------
// common_lru_way_allocator
// Way allocation / touch controller sitting after a one-hot pseudo-LRU tree.
// Picks a fill victim (lowest invalid way, else the LRU victim), holds it
// through the refill handshake, then commits it (valid bit + LRU touch).
// Hit touches share the single LRU update port; a commit has priority.
//
// Optional feature macro: COMMON_LRU_WAY_ALLOCATOR_ONEHOT_ERR_EN
//   adds err_onehot, a sticky flag set when the LRU victim is sampled while
//   not exactly one-hot.
//
// Ports (W = 1 << WAY_COUNT_LOG2):
//   clk          in   1  clock
//   reset        in   1  asynchronous active-low reset
//   lru_qaddr    in   W  one-hot LRU victim from the tree
//   lru_waddr    out  W  registered touch address to the tree
//   lru_wen      out  1  registered touch strobe
//   alloc_valid  in   1  allocation request
//   alloc_ready  out  1  idle, request can be accepted
//   alloc_way    out  W  granted way, stable while alloc_busy
//   alloc_busy   out  1  allocation outstanding
//   fill_done    in   1  refill complete, commit
//   fill_abort   in   1  refill cancelled (wins over fill_done)
//   touch_valid  in   1  hit-touch request
//   touch_way    in   W  way hit
//   touch_ready  out  1  touch accepted this cycle
//   inv_en       in   1  invalidate ways in inv_way
//   inv_way      in   W  invalidate mask
//   inv_all      in   1  clear all valid bits
//   way_valid    out  W  per-way valid bits
//   err_onehot   out  1  (macro only) sticky non-one-hot victim flag
// -----------------------------------------------------------------------------
module common_lru_way_allocator
  import common_lru_pkg::*;
#(
  parameter  int WAY_COUNT_LOG2 = 2,
  localparam int W              = 1 << WAY_COUNT_LOG2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] lru_qaddr,
  output logic [W-1:0] lru_waddr,
  output logic         lru_wen,
  input  logic         alloc_valid,
  output logic         alloc_ready,
  output logic [W-1:0] alloc_way,
  output logic         alloc_busy,
  input  logic         fill_done,
  input  logic         fill_abort,
  input  logic         touch_valid,
  input  logic [W-1:0] touch_way,
  output logic         touch_ready,
  input  logic         inv_en,
  input  logic [W-1:0] inv_way,
  input  logic         inv_all,
  output logic [W-1:0] way_valid
`ifdef COMMON_LRU_WAY_ALLOCATOR_ONEHOT_ERR_EN
  ,
  output logic         err_onehot
`endif
);

  alloc_state_t state_reg, state_next;
  logic [W-1:0] alloc_way_reg, alloc_way_next;
  logic [W-1:0] way_valid_reg, way_valid_next;
  logic [W-1:0] lru_waddr_reg, lru_waddr_next;
  logic         lru_wen_reg, lru_wen_next;

  logic [W-1:0] free_low, victim_low, victim, inv_mask;
  logic         accept, commit, abort, touch_accept, any_free;

  common_lru_way_prio_onehot #(.W(W)) u_free_prio (
    .vec (~way_valid_reg),
    .low (free_low)
  );

  common_lru_way_prio_onehot #(.W(W)) u_victim_prio (
    .vec (lru_qaddr),
    .low (victim_low)
  );

  assign any_free     = ~&way_valid_reg;
  // A zero victim from the tree falls back to way 0.
  assign victim       = any_free ? free_low
                      : ((victim_low != '0) ? victim_low : {{(W-1){1'b0}}, 1'b1});

  assign accept       = alloc_valid & (state_reg == ST_IDLE);
  assign commit       = (state_reg == ST_ALLOC) & fill_done & ~fill_abort;
  assign abort        = (state_reg == ST_ALLOC) & fill_abort;
  assign touch_ready  = ~commit;
  assign touch_accept = touch_valid & touch_ready;

  assign inv_mask     = inv_all ? '1 : (inv_en ? inv_way : '0);

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (accept)           state_next = ST_ALLOC;
      ST_ALLOC: if (commit || abort)  state_next = ST_IDLE;
      default:                        state_next = ST_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    alloc_way_next = alloc_way_reg;
    lru_wen_next   = 1'b0;
    lru_waddr_next = lru_waddr_reg;
    if (accept) begin
      alloc_way_next = victim;
    end
    if (commit) begin
      lru_wen_next   = 1'b1;
      lru_waddr_next = alloc_way_reg;
    end else if (touch_accept) begin
      lru_wen_next   = 1'b1;
      lru_waddr_next = touch_way;
    end
    // Invalidate is applied after the commit set so it wins on the same way.
    way_valid_next = (way_valid_reg | (commit ? alloc_way_reg : '0)) & ~inv_mask;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      alloc_way_reg <= '0;
      way_valid_reg <= '0;
      lru_wen_reg   <= 1'b0;
      lru_waddr_reg <= '0;
    end else begin
      state_reg     <= state_next;
      alloc_way_reg <= alloc_way_next;
      way_valid_reg <= way_valid_next;
      lru_wen_reg   <= lru_wen_next;
      lru_waddr_reg <= lru_waddr_next;
    end
  end

`ifdef COMMON_LRU_WAY_ALLOCATOR_ONEHOT_ERR_EN
  logic err_reg;

  // The victim path only samples lru_qaddr when an accept finds no free way.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_reg <= 1'b0;
    end else if (accept && !any_free && !onehot_check(MAX_WAYS'(lru_qaddr))) begin
      err_reg <= 1'b1;
    end
  end

  assign err_onehot = err_reg;
`endif

  assign alloc_ready = (state_reg == ST_IDLE);
  assign alloc_busy  = (state_reg == ST_ALLOC);
  assign alloc_way   = alloc_way_reg;
  assign way_valid   = way_valid_reg;
  assign lru_wen     = lru_wen_reg;
  assign lru_waddr   = lru_waddr_reg;

endmodule

// File: tb/tb_common_lru_way_allocator.sv
// -----------------------------------------------------------------------------
// tb_common_lru_way_allocator
// Directed scenarios followed by randomized traffic. Each driven cycle the
// reference model pushes the expected post-edge state and any expected LRU
// touch; a monitor pops and compares after every rising edge.
// -----------------------------------------------------------------------------
module tb_common_lru_way_allocator;

  localparam int WL = 2;
  localparam int W  = 1 << WL;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] lru_qaddr = '0;
  logic [W-1:0] lru_waddr;
  logic         lru_wen;
  logic         alloc_valid = 1'b0;
  logic         alloc_ready;
  logic [W-1:0] alloc_way;
  logic         alloc_busy;
  logic         fill_done = 1'b0;
  logic         fill_abort = 1'b0;
  logic         touch_valid = 1'b0;
  logic [W-1:0] touch_way = '0;
  logic         touch_ready;
  logic         inv_en = 1'b0;
  logic [W-1:0] inv_way = '0;
  logic         inv_all = 1'b0;
  logic [W-1:0] way_valid;
`ifdef COMMON_LRU_WAY_ALLOCATOR_ONEHOT_ERR_EN
  logic         err_onehot;
`endif

  always #5 clk = ~clk;

  common_lru_way_allocator #(.WAY_COUNT_LOG2(WL)) dut (
    .clk         (clk),
    .reset       (reset),
    .lru_qaddr   (lru_qaddr),
    .lru_waddr   (lru_waddr),
    .lru_wen     (lru_wen),
    .alloc_valid (alloc_valid),
    .alloc_ready (alloc_ready),
    .alloc_way   (alloc_way),
    .alloc_busy  (alloc_busy),
    .fill_done   (fill_done),
    .fill_abort  (fill_abort),
    .touch_valid (touch_valid),
    .touch_way   (touch_way),
    .touch_ready (touch_ready),
    .inv_en      (inv_en),
    .inv_way     (inv_way),
    .inv_all     (inv_all),
    .way_valid   (way_valid)
`ifdef COMMON_LRU_WAY_ALLOCATOR_ONEHOT_ERR_EN
    ,
    .err_onehot  (err_onehot)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0] valid;
    logic [W-1:0] waddr;
    logic [W-1:0] way;
    logic         wen;
    logic         busy;
    logic         err;
  } snap_t;

  snap_t        snap_q[$];
  logic [W-1:0] touch_q[$];

  // Reference model: plain per-way flags and an index for the held way.
  bit           mv [W];
  bit           mbusy;
  int           mway;
  logic [W-1:0] mwaddr;
  bit           merr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [W-1:0] v);
    for (int i = 0; i < W; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [W-1:0] model_valid();
    logic [W-1:0] v;
    for (int i = 0; i < W; i++) v[i] = mv[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < W; i++) mv[i] = 1'b0;
    mbusy  = 1'b0;
    mway   = 0;
    mwaddr = '0;
    merr   = 1'b0;
  endtask

  task automatic step(input bit av, input bit fd, input bit fa, input bit tv,
                      input logic [W-1:0] tw, input bit ie, input logic [W-1:0] iw,
                      input bit ia, input logic [W-1:0] q);
    bit           acc, com, wen;
    int           nway;
    snap_t        s;
    logic [W-1:0] vv;
    @(negedge clk);
    alloc_valid = av; fill_done = fd; fill_abort = fa; touch_valid = tv;
    touch_way = tw; inv_en = ie; inv_way = iw; inv_all = ia; lru_qaddr = q;
    #1;
    acc = av && !mbusy;
    com = mbusy && fd && !fa;
    chk("touch_ready", touch_ready, !com);
    wen = 1'b0;
    if (com) begin
      mwaddr = W'(1) << mway; wen = 1'b1; touch_q.push_back(mwaddr);
    end else if (tv) begin
      mwaddr = tw; wen = 1'b1; touch_q.push_back(tw);
    end
    vv   = model_valid();
    nway = mway;
    if (acc) begin
      nway = lowest(~vv);
      if (nway < 0) begin
        nway = lowest(q);
        if (nway < 0) nway = 0;
        if (!$onehot(q)) merr = 1'b1;
      end
    end
    if (com) mv[mway] = 1'b1;
    for (int i = 0; i < W; i++) if (ia || (ie && iw[i])) mv[i] = 1'b0;
    if (acc) begin
      mbusy = 1'b1; mway = nway;
    end else if (mbusy && (com || fa)) begin
      mbusy = 1'b0;
    end
    s.valid = model_valid(); s.waddr = mwaddr; s.way = W'(1) << mway;
    s.wen = wen; s.busy = mbusy; s.err = merr;
    snap_q.push_back(s);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, '0, 0, '0, 0, '0);
  endtask

  // Asynchronous reset between edges, checked immediately.
  task automatic do_reset();
    @(negedge clk);
    alloc_valid = 0; fill_done = 0; fill_abort = 0; touch_valid = 0;
    inv_en = 0; inv_all = 0;
    #2 reset = 1'b0;
    #1;
    chk("rst_way_valid", way_valid, 0);
    chk("rst_lru_wen", lru_wen, 0);
    chk("rst_lru_waddr", lru_waddr, 0);
    chk("rst_alloc_way", alloc_way, 0);
    chk("rst_alloc_busy", alloc_busy, 0);
    chk("rst_alloc_ready", alloc_ready, 1);
    snap_q.delete();
    touch_q.delete();
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    $display("reset applied at %0t", $time);
  endtask

  // Monitor: compares after every rising edge.
  always begin : monitor
    snap_t        s;
    logic [W-1:0] t;
    @(posedge clk);
    #1;
    if (reset && snap_q.size() > 0) begin
      s = snap_q.pop_front();
      chk("way_valid", way_valid, s.valid);
      chk("alloc_busy", alloc_busy, s.busy);
      chk("alloc_ready", alloc_ready, !s.busy);
      chk("lru_wen", lru_wen, s.wen);
      chk("lru_waddr", lru_waddr, s.waddr);
      if (s.busy) chk("alloc_way", alloc_way, s.way);
`ifdef COMMON_LRU_WAY_ALLOCATOR_ONEHOT_ERR_EN
      chk("err_onehot", err_onehot, s.err);
`endif
    end
    if (reset && lru_wen) begin
      if (touch_q.size() == 0) begin
        chk("touch_unexpected", lru_waddr, 0);
        if (lru_waddr == '0) chk("touch_unexpected_wen", lru_wen, 0);
      end else begin
        t = touch_q.pop_front();
        chk("touch_waddr", lru_waddr, t);
        $display("touch waddr=%b expected=%b", lru_waddr, t);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [W-1:0] q, tw, iw;
    model_reset();
    #2 reset = 1'b0;
    #1;
    chk("init_way_valid", way_valid, 0);
    chk("init_lru_wen", lru_wen, 0);
    chk("init_lru_waddr", lru_waddr, 0);
    chk("init_alloc_way", alloc_way, 0);
    chk("init_alloc_ready", alloc_ready, 1);
    chk("init_alloc_busy", alloc_busy, 0);
    @(negedge clk);
    reset = 1'b1;

    // 1: first allocation takes way 0, commit touches it
    step(1, 0, 0, 0, '0, 0, '0, 0, 4'b0100);
    step(0, 1, 0, 0, '0, 0, '0, 0, '0);
    idle();

    // 2: four back-to-back allocations fill every way
    do_reset();
    for (int i = 0; i < W; i++) begin
      step(1, 0, 0, 0, '0, 0, '0, 0, 4'b1000);
      step(0, 1, 0, 0, '0, 0, '0, 0, '0);
    end
    idle();

    // 3: all valid, victim latched at accept ignores later qaddr changes
    step(1, 0, 0, 0, '0, 0, '0, 0, 4'b0100);
    step(0, 0, 0, 0, '0, 0, '0, 0, 4'b0001);
    step(0, 1, 0, 0, '0, 0, '0, 0, 4'b0001);
    idle();

    // 4: commit blocks a same-cycle touch; retry is accepted
    step(1, 0, 0, 0, '0, 0, '0, 0, 4'b1000);
    step(0, 1, 0, 1, 4'b0010, 0, '0, 0, '0);
    step(0, 0, 0, 1, 4'b0010, 0, '0, 0, '0);
    idle();

    // 5: abort wins over done
    step(1, 0, 0, 0, '0, 0, '0, 0, 4'b0010);
    step(0, 1, 1, 0, '0, 0, '0, 0, '0);
    idle();

    // 6: invalidate beats commit on the same way; touch still issues
    step(0, 0, 0, 0, '0, 1, 4'b0100, 0, '0);
    step(1, 0, 0, 0, '0, 0, '0, 0, 4'b0001);
    step(0, 1, 0, 0, '0, 1, 4'b0100, 0, '0);
    idle();
    // reset in the middle of an allocation
    step(1, 0, 0, 0, '0, 0, '0, 0, 4'b0001);
    do_reset();
    idle();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      q  = ($urandom_range(0, 9) < 7) ? (W'(1) << $urandom_range(0, W-1)) : W'($urandom_range(0, (1 << W) - 1));
      tw = W'(1) << $urandom_range(0, W-1);
      iw = W'($urandom_range(0, (1 << W) - 1));
      if (i == 800) do_reset();
      step($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) < 4, tw, $urandom_range(0, 9) == 0, iw,
           $urandom_range(0, 29) == 0, q);
    end
    idle();
    idle();
    @(posedge clk);
    #3;
    chk("touch_queue_drained", touch_q.size(), 0);
    chk("snap_queue_drained", snap_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
